evg_event_arbiter: RTL and testbench
====================================

# evg_event_arbiter

Merges the event-code request streams of the event generator into the single event-code stream the transmitter sends. It sits directly downstream of the hardware-trigger stage and alongside the sequencer and software request sources. In every transmit slot it grants at most one request using fixed priority, and it inserts a periodic heartbeat event. The merged code is registered for the transceiver data path.

## Interface
- `EVENTCODE_WIDTH`, 8, width of every event code.
- `HEARTBEAT_CODE`, 8'h7A, code sent as the heartbeat.
- `HEARTBEAT_INTERVAL`, 125000, number of slots between heartbeats; must be ≥ 2.
- `evgTxClk`  in  1  transmit clock; all logic is in this domain.
- `evgTxResetN`  in  1  reset, **asynchronous assert, active-low**.
- `slotStrobe`  in  1  the current cycle is an event slot.
- `heartbeatEnable`  in  1  enables heartbeat generation; level-sensitive.
- `seqEventTDATA`/`seqEventTVALID`/`seqEventTREADY`  in/in/out  EVENTCODE_WIDTH/1/1  sequencer requests.
- `hwEventTDATA`/`hwEventTVALID`/`hwEventTREADY`  in/in/out  EVENTCODE_WIDTH/1/1  hardware-trigger requests.
- `swEventTDATA`/`swEventTVALID`/`swEventTREADY`  in/in/out  EVENTCODE_WIDTH/1/1  software requests.
- `evgTxCode`  out  EVENTCODE_WIDTH  code for the slot last processed.
- `evgTxCodeValid`  out  1  one-cycle pulse when a non-zero code is loaded into `evgTxCode`.
- `statClear`  in  1  synchronous clear of the statistics counters.
- `statSeq`, `statHw`, `statSw`, `statHeartbeat`  out  16 each  count of events sent from each source.

## Operation
- **Priority within a slot (highest first):** pending heartbeat, then seq, then hw, then sw.
  - Only one grant is made per slot.
  - Nothing is granted on cycles where `slotStrobe` is low.
- **Ready signals are combinational:**
  - `seqEventTREADY = slotStrobe & seqEventTVALID & !hbPending`.
  - `hwEventTREADY` and `swEventTREADY` follow the same form, additionally gated by the absence of every higher-priority valid or pending request.
  - At most one TREADY is high in any cycle.
  - No TREADY is high while the heartbeat is granted.
- **Transfers:** a transfer occurs when TVALID and TREADY are both high in the same cycle.
  - Sources must hold TDATA stable while TVALID is high.
  - The arbiter never withdraws a grant once made.
- **Zero codes:** a source transfer with TDATA = 0 is accepted and consumed.
  - It transmits idle: `evgTxCode` is set to 0 and `evgTxCodeValid` stays low.
  - It is not counted.
- **Heartbeat timer:**
  - The slot counter, `$clog2(HEARTBEAT_INTERVAL)` bits wide, increments on each `slotStrobe`.
  - On the strobe where the counter equals `HEARTBEAT_INTERVAL-1`, it wraps to 0 and sets `hbPending`.
  - `hbPending` is granted at the next `slotStrobe`, then cleared.
  - If a terminal count arrives while `hbPending` is still set, `hbPending` stays set; there is no double heartbeat.
- **`heartbeatEnable` low:** the counter is held at 0 and `hbPending` is cleared at the next clock edge.
- **Output register:**
  - On every `slotStrobe` edge, `evgTxCode` loads the granted code, or 0 if there is no grant.
  - On non-slot cycles, `evgTxCode` holds its value.
  - `evgTxCodeValid` is high only in the cycle after a slot that granted a non-zero code.

## Timing
- Latency from grant (TVALID & TREADY in cycle N) to the code on `evgTxCode`/`evgTxCodeValid` is 1 cycle (N+1).
- Heartbeat latency: the terminal-count slot sets `hbPending`; the heartbeat is emitted on the following slot and appears one cycle after that slot's edge.
- **Back-to-back slots** (`slotStrobe` held high) sustain one grant per cycle.
  - A source holding TVALID continuously is served every slot unless pre-empted by a higher priority.
  - Lower sources may starve; this is intended.
- **Reset** (`evgTxResetN` low, at any time including mid-handshake):
  - `evgTxCode`=0, `evgTxCodeValid`=0, `hbPending`=0, slot counter=0, and all stat counters=0, asynchronously.
  - All TREADY outputs are low while reset is asserted.
  - A request pending at reset stays valid upstream and is granted at the first slot after release.
- **Reset release** is taken synchronously: the first `slotStrobe` edge after deassertion behaves normally.

## Configuration
- Macro `EVG_EVENT_ARBITER_STATS_EN`.
- **Defined:** four 16-bit counters, each incremented on the edge that loads a non-zero code from its source.
  - Counters saturate at 16'hFFFF.
  - `statClear` zeroes all four on the next edge and takes precedence over an increment in the same cycle.
- **Undefined:** the stat ports are driven constant 0, `statClear` is ignored, and no counter logic is synthesized.
- Arbitration behaviour is identical in both builds.

## Test plan
- **Single hw request:**
  - Stimulus: `hwEventTDATA`=8'h2C, TVALID held; `slotStrobe` pulses every 4 cycles.
  - Response: `hwEventTREADY` is high only in the slot cycle; `evgTxCode`=8'h2C with `evgTxCodeValid` the next cycle; TREADY is low in the non-slot cycles before it.
- **Simultaneous requests:**
  - Stimulus: seq=8'h10, hw=8'h20, sw=8'h30 all valid; `slotStrobe` held high.
  - Response: codes appear as 10, 20, 30 on consecutive cycles; exactly one TREADY is high per cycle.
- **Heartbeat pre-emption:**
  - Stimulus: `HEARTBEAT_INTERVAL`=4, `heartbeatEnable`=1, seq continuously valid with 8'h11; `slotStrobe` held high.
  - Response: 8'h7A appears once every 4 slots, 8'h11 fills the other slots, and `seqEventTREADY` is low in each heartbeat slot.
- **Zero code:**
  - Stimulus: sw TDATA=0, valid.
  - Response: the request is accepted, `evgTxCode`=0, `evgTxCodeValid` stays low, and `statSw` is unchanged.
- **Reset mid-operation:**
  - Stimulus: assert `evgTxResetN` low between `clk` edges while `evgTxCode`=8'h20 and `hbPending`=1.
  - Response: the outputs go to 0 before the next edge; after release the held hw request is granted on the first slot; there is no stale heartbeat.
- **Stats (macro defined):**
  - Stimulus: preload `statHw` near saturation, then send 3 more hw events; assert `statClear` together with an increment.
  - Response: `statHw` stays at 16'hFFFF; after the clear it reads 0.

Source files
------------

// File: rtl/evg_event_arbiter_if.sv
// evg_event_arbiter_if: request/response bundle between the event sources and the event arbiter.
// Ports (signals): slotStrobe, heartbeatEnable, statClear (to arbiter);
//   seq/hw/sw EventTDATA/TVALID (to arbiter), EventTREADY (from arbiter);
//   evgTxCode, evgTxCodeValid, statSeq/statHw/statSw/statHeartbeat (from arbiter).
// Modports: master = sources/transmitter side, slave = arbiter side.
interface evg_event_arbiter_if #(
    parameter int EVENTCODE_WIDTH = 8
);
    logic                       slotStrobe;
    logic                       heartbeatEnable;
    logic [EVENTCODE_WIDTH-1:0] seqEventTDATA;
    logic                       seqEventTVALID;
    logic                       seqEventTREADY;
    logic [EVENTCODE_WIDTH-1:0] hwEventTDATA;
    logic                       hwEventTVALID;
    logic                       hwEventTREADY;
    logic [EVENTCODE_WIDTH-1:0] swEventTDATA;
    logic                       swEventTVALID;
    logic                       swEventTREADY;
    logic [EVENTCODE_WIDTH-1:0] evgTxCode;
    logic                       evgTxCodeValid;
    logic                       statClear;
    logic [15:0]                statSeq;
    logic [15:0]                statHw;
    logic [15:0]                statSw;
    logic [15:0]                statHeartbeat;

    modport master (
        output slotStrobe, heartbeatEnable, statClear,
        output seqEventTDATA, seqEventTVALID, hwEventTDATA, hwEventTVALID, swEventTDATA, swEventTVALID,
        input  seqEventTREADY, hwEventTREADY, swEventTREADY,
        input  evgTxCode, evgTxCodeValid, statSeq, statHw, statSw, statHeartbeat
    );

    modport slave (
        input  slotStrobe, heartbeatEnable, statClear,
        input  seqEventTDATA, seqEventTVALID, hwEventTDATA, hwEventTVALID, swEventTDATA, swEventTVALID,
        output seqEventTREADY, hwEventTREADY, swEventTREADY,
        output evgTxCode, evgTxCodeValid, statSeq, statHw, statSw, statHeartbeat
    );
endinterface

// File: rtl/evg_event_arbiter.sv
// evg_event_arbiter: fixed-priority merge of heartbeat/seq/hw/sw event codes into one registered tx code stream.
// Ports: evgTxClk (transmit clock), evgTxResetN (async active-low reset),
//   bus (evg_event_arbiter_if.slave): slot strobe, heartbeat enable, three valid/ready request
//   streams, registered evgTxCode/evgTxCodeValid, statistics counters and their clear.
// Build option: define EVG_EVENT_ARBITER_STATS_EN to include the saturating per-source counters;
//   otherwise the stat outputs are tied to 0 and statClear is ignored.
module evg_event_arbiter #(
    parameter int                         EVENTCODE_WIDTH    = 8,
    parameter logic [EVENTCODE_WIDTH-1:0] HEARTBEAT_CODE     = 8'h7A,
    parameter int                         HEARTBEAT_INTERVAL = 125000
) (
    input  logic                  evgTxClk,
    input  logic                  evgTxResetN,
    evg_event_arbiter_if.slave    bus
);
    localparam int CW = $clog2(HEARTBEAT_INTERVAL);
    localparam logic [CW-1:0] TERM = CW'(HEARTBEAT_INTERVAL - 1);

    logic [CW-1:0]              slotCnt;
    logic                       hbPending;
    logic [EVENTCODE_WIDTH-1:0] codeR;
    logic                       validR;
    logic                       slotActive;
    logic                       hbGrant;
    logic [EVENTCODE_WIDTH-1:0] grantCode;

    // Readies are masked during reset so no transfer can be seen while state is being cleared.
    assign slotActive = bus.slotStrobe & evgTxResetN;
    assign hbGrant    = slotActive & hbPending;
    assign bus.seqEventTREADY = slotActive & bus.seqEventTVALID & ~hbPending;
    assign bus.hwEventTREADY  = slotActive & bus.hwEventTVALID & ~hbPending & ~bus.seqEventTVALID;
    assign bus.swEventTREADY  = slotActive & bus.swEventTVALID & ~hbPending & ~bus.seqEventTVALID & ~bus.hwEventTVALID;

    always_comb
        grantCode = hbPending           ? HEARTBEAT_CODE    :
                    bus.seqEventTVALID  ? bus.seqEventTDATA :
                    bus.hwEventTVALID   ? bus.hwEventTDATA  :
                    bus.swEventTVALID   ? bus.swEventTDATA  : '0;

    // A pending heartbeat is always granted on the next slot, so hbPending simply
    // tracks whether the slot just processed was the terminal count.
    always_ff @(posedge evgTxClk or negedge evgTxResetN)
        if (!evgTxResetN) begin
            slotCnt   <= '0;
            hbPending <= 1'b0;
            codeR     <= '0;
            validR    <= 1'b0;
        end else begin
            if (!bus.heartbeatEnable) begin
                slotCnt   <= '0;
                hbPending <= 1'b0;
            end else if (bus.slotStrobe) begin
                slotCnt   <= (slotCnt == TERM) ? '0 : slotCnt + CW'(1);
                hbPending <= (slotCnt == TERM);
            end
            codeR  <= bus.slotStrobe ? grantCode : codeR;
            validR <= bus.slotStrobe & (|grantCode);
        end

    assign bus.evgTxCode      = codeR;
    assign bus.evgTxCodeValid = validR;

`ifdef EVG_EVENT_ARBITER_STATS_EN
    logic [3:0][15:0] statR;
    logic [3:0]       statInc;

    assign statInc = {hbGrant,
                      bus.swEventTREADY  & (|bus.swEventTDATA),
                      bus.hwEventTREADY  & (|bus.hwEventTDATA),
                      bus.seqEventTREADY & (|bus.seqEventTDATA)};

    always_ff @(posedge evgTxClk or negedge evgTxResetN)
        if (!evgTxResetN)
            statR <= '0;
        else
            for (int i = 0; i < 4; i++)
                statR[i] <= bus.statClear ? 16'h0 :
                            (statInc[i] && statR[i] != 16'hFFFF) ? statR[i] + 16'h1 : statR[i];

    assign bus.statSeq       = statR[0];
    assign bus.statHw        = statR[1];
    assign bus.statSw        = statR[2];
    assign bus.statHeartbeat = statR[3];
`else
    assign bus.statSeq       = 16'h0;
    assign bus.statHw        = 16'h0;
    assign bus.statSw        = 16'h0;
    assign bus.statHeartbeat = 16'h0;
`endif
endmodule

// File: tb/tb_evg_event_arbiter.sv
// tb_evg_event_arbiter: directed self-checking bench for evg_event_arbiter (heartbeat interval 4).
// Ports: none. Drives the request streams through the interface and checks readies and tx codes.
module tb_evg_event_arbiter;
    logic evgTxClk = 1'b0;
    logic evgTxResetN = 1'b0;
    int   nChecks = 0;
    int   nFails = 0;

    always #5 evgTxClk = ~evgTxClk;

    evg_event_arbiter_if #(.EVENTCODE_WIDTH(8)) bus ();

    evg_event_arbiter #(
        .EVENTCODE_WIDTH(8),
        .HEARTBEAT_CODE(8'h7A),
        .HEARTBEAT_INTERVAL(4)
    ) dut (
        .evgTxClk(evgTxClk),
        .evgTxResetN(evgTxResetN),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge evgTxClk);
        #1;
    endtask

    initial begin
        bus.slotStrobe = 1'b1;
        bus.heartbeatEnable = 1'b0;
        bus.statClear = 1'b0;
        bus.seqEventTDATA = 8'h55;
        bus.seqEventTVALID = 1'b1;
        bus.hwEventTDATA = 8'h0;
        bus.hwEventTVALID = 1'b0;
        bus.swEventTDATA = 8'h0;
        bus.swEventTVALID = 1'b0;
        #1;
        chk("rst_code", bus.evgTxCode, 8'h0);
        chk("rst_valid", bus.evgTxCodeValid, 1'b0);
        chk("rst_seq_ready", bus.seqEventTREADY, 1'b0);
        tick();
        chk("rst_hold_code", bus.evgTxCode, 8'h0);
        bus.slotStrobe = 1'b0;
        bus.seqEventTVALID = 1'b0;
        #2 evgTxResetN = 1'b1;
        tick();
        chk("idle_code", bus.evgTxCode, 8'h0);

        // single hw request, slot every 4 cycles
        bus.hwEventTDATA = 8'h2C;
        bus.hwEventTVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hw_ready_nonslot", bus.hwEventTREADY, 1'b0);
            tick();
        end
        bus.slotStrobe = 1'b1;
        #1 chk("hw_ready_slot", bus.hwEventTREADY, 1'b1);
        tick();
        chk("hw_code", bus.evgTxCode, 8'h2C);
        chk("hw_valid", bus.evgTxCodeValid, 1'b1);
        bus.hwEventTVALID = 1'b0;
        bus.slotStrobe = 1'b0;
        tick();
        chk("hold_code", bus.evgTxCode, 8'h2C);
        chk("hold_valid", bus.evgTxCodeValid, 1'b0);

        // simultaneous requests, slots back to back
        bus.seqEventTDATA = 8'h10; bus.seqEventTVALID = 1'b1;
        bus.hwEventTDATA = 8'h20;  bus.hwEventTVALID = 1'b1;
        bus.swEventTDATA = 8'h30;  bus.swEventTVALID = 1'b1;
        bus.slotStrobe = 1'b1;
        #1 chk("sim_readies_a", {bus.seqEventTREADY, bus.hwEventTREADY, bus.swEventTREADY}, 3'b100);
        tick();
        chk("sim_code_a", bus.evgTxCode, 8'h10);
        bus.seqEventTVALID = 1'b0;
        #1 chk("sim_readies_b", {bus.seqEventTREADY, bus.hwEventTREADY, bus.swEventTREADY}, 3'b010);
        tick();
        chk("sim_code_b", bus.evgTxCode, 8'h20);
        bus.hwEventTVALID = 1'b0;
        #1 chk("sim_readies_c", {bus.seqEventTREADY, bus.hwEventTREADY, bus.swEventTREADY}, 3'b001);
        tick();
        chk("sim_code_c", bus.evgTxCode, 8'h30);
        chk("sim_valid_c", bus.evgTxCodeValid, 1'b1);

        // zero code from sw: consumed, transmits idle
        bus.swEventTDATA = 8'h00;
        #1 chk("zero_ready", bus.swEventTREADY, 1'b1);
        tick();
        chk("zero_code", bus.evgTxCode, 8'h0);
        chk("zero_valid", bus.evgTxCodeValid, 1'b0);
        bus.swEventTVALID = 1'b0;
        tick();
        chk("nogrant_code", bus.evgTxCode, 8'h0);
        chk("nogrant_valid", bus.evgTxCodeValid, 1'b0);

        // heartbeat pre-emption: heartbeats land on slots 5 and 9
        bus.heartbeatEnable = 1'b1;
        bus.seqEventTDATA = 8'h11;
        bus.seqEventTVALID = 1'b1;
        #1;
        for (int i = 1; i <= 11; i++) begin
            chk($sformatf("hb_seq_ready_%0d", i), bus.seqEventTREADY, (i == 5 || i == 9) ? 1'b0 : 1'b1);
            tick();
            chk($sformatf("hb_code_%0d", i), bus.evgTxCode, (i == 5 || i == 9) ? 8'h7A : 8'h11);
            chk($sformatf("hb_valid_%0d", i), bus.evgTxCodeValid, 1'b1);
        end
        // slot 12 is the terminal count: hw 8'h20 granted, heartbeat becomes pending
        bus.seqEventTVALID = 1'b0;
        bus.hwEventTDATA = 8'h20;
        bus.hwEventTVALID = 1'b1;
        #1 chk("pre_rst_hw_ready", bus.hwEventTREADY, 1'b1);
        tick();
        chk("pre_rst_code", bus.evgTxCode, 8'h20);
`ifdef EVG_EVENT_ARBITER_STATS_EN
        chk("stat_heartbeat", bus.statHeartbeat, 16'd2);
        chk("stat_seq", bus.statSeq, 16'd10);
        chk("stat_sw", bus.statSw, 16'd1);
`endif

        // reset mid-operation with the hw request held
        #2 evgTxResetN = 1'b0;
        #1;
        chk("midrst_code", bus.evgTxCode, 8'h0);
        chk("midrst_valid", bus.evgTxCodeValid, 1'b0);
        chk("midrst_hw_ready", bus.hwEventTREADY, 1'b0);
        #2 evgTxResetN = 1'b1;
        #1 chk("post_rst_hw_ready", bus.hwEventTREADY, 1'b1);
        tick();
        chk("post_rst_code", bus.evgTxCode, 8'h20);
        chk("post_rst_valid", bus.evgTxCodeValid, 1'b1);
        bus.heartbeatEnable = 1'b0;

`ifdef EVG_EVENT_ARBITER_STATS_EN
        chk("stat_hw_after_rst", bus.statHw, 16'd1);
        for (int i = 0; i < 65532; i++) tick();
        chk("stat_hw_near_sat", bus.statHw, 16'hFFFD);
        for (int i = 0; i < 3; i++) tick();
        chk("stat_hw_sat", bus.statHw, 16'hFFFF);
        bus.statClear = 1'b1;
        tick();
        chk("stat_hw_clear", bus.statHw, 16'h0);
        bus.statClear = 1'b0;
        tick();
        chk("stat_hw_after_clear", bus.statHw, 16'h1);
`else
        bus.statClear = 1'b1;
        tick();
        chk("stat_off", {bus.statSeq, bus.statHw}, 32'h0);
        chk("stat_off_b", {bus.statSw, bus.statHeartbeat}, 32'h0);
`endif
        bus.hwEventTVALID = 1'b0;
        bus.slotStrobe = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
